// File: rtl/matrix_column_scanner_if.sv
// rtl/matrix_column_scanner_if.sv - ROM read bus between the column scanner and the pattern ROM
interface matrix_column_scanner_if #(
    parameter int WIDTH = 7,
    parameter int ADDR  = 4
);
    logic [ADDR-1:0]  rom_addr;
    logic             rom_en;
    logic [WIDTH-1:0] rom_data;

    modport master (output rom_addr, output rom_en, input rom_data);
    modport slave  (input rom_addr, input rom_en, output rom_data);
endinterface

// File: rtl/matrix_column_scanner.sv
// rtl/matrix_column_scanner.sv - scans a character from the pattern ROM onto an active-low LED dot matrix
module matrix_column_scanner #(
    parameter int WIDTH = 7,
    parameter int ADDR  = 4,
    parameter int COLS  = 5,
    parameter int DWELL = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [ADDR-1:0]           base_addr,
    matrix_column_scanner_if.master   rom,
    output logic [WIDTH-1:0]          row_out,
    output logic [COLS-1:0]           col_sel,
    output logic                      busy,
    output logic                      frame_done
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DW = ($clog2(DWELL + 1) > 0) ? $clog2(DWELL + 1) : 1;
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, BLANK, FETCH, SHOW} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    col_idx_q, col_idx_d;
    logic [DW-1:0]    dwell_cnt_q, dwell_cnt_d;
    logic [ADDR-1:0]  frame_base_q, frame_base_d;
    logic [ADDR-1:0]  rom_addr_q, rom_addr_d;
    logic             rom_en_q, rom_en_d;
    logic [WIDTH-1:0] row_out_q, row_out_d;
    logic [COLS-1:0]  col_sel_q, col_sel_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;

    always_comb begin
        state_d      = state_q;
        col_idx_d    = col_idx_q;
        dwell_cnt_d  = dwell_cnt_q;
        frame_base_d = frame_base_q;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d      = BLANK;
                    col_idx_d    = '0;
                    frame_base_d = base_addr;
                end
            end
            BLANK: state_d = FETCH;
            FETCH: begin
                state_d     = SHOW;
                dwell_cnt_d = '0;
            end
            SHOW: begin
                if (dwell_cnt_q == DWELL_LAST) begin
                    state_d = BLANK;
                    if (col_idx_q < COL_LAST) begin
                        col_idx_d = col_idx_q + CW'(1);
                    end else begin
                        col_idx_d    = '0;
                        frame_base_d = base_addr;
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Dropping enable abandons the frame from any active state.
        if (state_q != IDLE && !enable) begin
            state_d     = IDLE;
            col_idx_d   = '0;
            dwell_cnt_d = '0;
        end
    end

    // Outputs are computed from the next state so each registered value lines up with its slot.
    always_comb begin
        busy_d       = (state_d != IDLE);
        rom_en_d     = (state_d == FETCH);
        rom_addr_d   = rom_addr_q;
        row_out_d    = '1;
        col_sel_d    = '1;
        frame_done_d = 1'b0;

        if (state_d == FETCH) begin
            rom_addr_d = frame_base_q + ADDR'(col_idx_q);
        end

        if (state_d == SHOW) begin
            // rom_data is only looked at while the ROM is enabled, so a floating bus never reaches the rows.
            row_out_d    = (state_q == FETCH) ? rom.rom_data : row_out_q;
            col_sel_d    = ~(COLS'(1) << col_idx_d);
            frame_done_d = (dwell_cnt_d == DWELL_LAST) && (col_idx_d == COL_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_idx_q    <= '0;
            dwell_cnt_q  <= '0;
            frame_base_q <= '0;
            rom_addr_q   <= '0;
            rom_en_q     <= 1'b0;
            row_out_q    <= '1;
            col_sel_q    <= '1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_idx_q    <= col_idx_d;
            dwell_cnt_q  <= dwell_cnt_d;
            frame_base_q <= frame_base_d;
            rom_addr_q   <= rom_addr_d;
            rom_en_q     <= rom_en_d;
            row_out_q    <= row_out_d;
            col_sel_q    <= col_sel_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rom.rom_addr = rom_addr_q;
    assign rom.rom_en   = rom_en_q;
    assign row_out      = row_out_q;
    assign col_sel      = col_sel_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
endmodule

// File: tb/tb_matrix_column_scanner.sv
// tb/tb_matrix_column_scanner.sv - scoreboard bench for matrix_column_scanner against a slot-arithmetic model
module tb_matrix_column_scanner;
    localparam int WIDTH = 7;
    localparam int ADDR  = 4;
    localparam int COLS  = 5;
    localparam int DWELL = 4;
    localparam int SLOT  = DWELL + 2;
    localparam int FRAME = COLS * SLOT;

    typedef struct {
        logic [WIDTH-1:0] row;
        logic [COLS-1:0]  col;
        logic             en;
        logic [ADDR-1:0]  addr;
        logic             busy;
        logic             fd;
    } exp_t;

    logic             clk = 1'b0;
    logic             clk_run = 1'b1;
    logic             rst_n;
    logic             enable;
    logic [ADDR-1:0]  base_addr;
    logic [WIDTH-1:0] row_out;
    logic [COLS-1:0]  col_sel;
    logic             busy;
    logic             frame_done;

    logic [WIDTH-1:0] rom_mem [16];
    exp_t             exp_q [$];
    int               n_tests = 0;
    int               n_fail  = 0;

    logic             m_run = 1'b0;
    int               m_t   = 0;
    logic [ADDR-1:0]  m_base = '0;

    matrix_column_scanner_if #(.WIDTH(WIDTH), .ADDR(ADDR)) rbus ();

    assign rbus.rom_data = rbus.rom_en ? rom_mem[rbus.rom_addr] : {WIDTH{1'bx}};

    matrix_column_scanner #(.WIDTH(WIDTH), .ADDR(ADDR), .COLS(COLS), .DWELL(DWELL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .base_addr  (base_addr),
        .rom        (rbus.master),
        .row_out    (row_out),
        .col_sel    (col_sel),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Expected outputs from elapsed time since the scan started: slot = column, phase within slot = blank/fetch/show.
    function automatic exp_t model_out();
        exp_t e;
        int ph, col;
        logic [ADDR-1:0] a;
        e.row = '1; e.col = '1; e.en = 1'b0; e.addr = '0; e.busy = m_run; e.fd = 1'b0;
        if (m_run) begin
            ph  = m_t % SLOT;
            col = (m_t / SLOT) % COLS;
            a   = m_base + ADDR'(col);
            if (ph == 1) begin
                e.en   = 1'b1;
                e.addr = a;
            end else if (ph >= 2) begin
                e.row = rom_mem[a];
                e.col = ~(COLS'(1) << col);
                e.fd  = (col == COLS - 1) && (ph == SLOT - 1);
            end
        end
        return e;
    endfunction

    task automatic step(input logic en, input logic [ADDR-1:0] b);
        enable    = en;
        base_addr = b;
        @(posedge clk);
        if (!m_run) begin
            if (en) begin
                m_run  = 1'b1;
                m_t    = 0;
                m_base = b;
            end
        end else if (!en) begin
            m_run = 1'b0;
        end else begin
            m_t = m_t + 1;
            if (m_t % FRAME == 0) m_base = b;
        end
        exp_q.push_back(model_out());
        #1;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, base_addr);
    endtask

    task automatic fill_rom_random();
        for (int i = 0; i < 16; i++) rom_mem[i] = WIDTH'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        n_tests++;
        if (row_out !== 7'h7F || col_sel !== 5'b11111 || rbus.rom_en !== 1'b0 ||
            rbus.rom_addr !== 4'h0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got row=%b col=%b en=%b addr=%h busy=%b fd=%b, want row=1111111 col=11111 en=0 addr=0 busy=0 fd=0",
                     tag, row_out, col_sel, rbus.rom_en, rbus.rom_addr, busy, frame_done);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            if (rbus.rom_en !== e.en || (e.en && rbus.rom_addr !== e.addr) || row_out !== e.row ||
                col_sel !== e.col || busy !== e.busy || frame_done !== e.fd) begin
                n_fail++;
                $display("FAIL cycle t=%0d: got row=%b col=%b en=%b addr=%h busy=%b fd=%b, want row=%b col=%b en=%b addr=%h busy=%b fd=%b",
                         m_t, row_out, col_sel, rbus.rom_en, rbus.rom_addr, busy, frame_done,
                         e.row, e.col, e.en, e.addr, e.busy, e.fd);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        base_addr = '0;
        fill_rom_random();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_initial");
        rst_n = 1'b1;

        // Character pattern from the test plan at addresses 0..4.
        rom_mem[0] = 7'b1100000; rom_mem[1] = 7'b1011011; rom_mem[2] = 7'b0111011;
        rom_mem[3] = 7'b1011011; rom_mem[4] = 7'b1100000;
        for (int i = 0; i < 2 * FRAME + 3; i++) step(1'b1, 4'd0);
        idle_steps(3);

        fill_rom_random();
        for (int i = 0; i < FRAME + 4; i++) step(1'b1, 4'd14);
        idle_steps(3);

        // Base switches 0 -> 5 during column 2; only the next frame may see it.
        for (int i = 0; i < 2 * FRAME + 2; i++) step(1'b1, (i < 2 * SLOT + 3) ? 4'd0 : 4'd5);
        idle_steps(3);

        // Enable dropped in column 1 SHOW, then restarted at a new base.
        for (int i = 0; i < SLOT + 3; i++) step(1'b1, 4'd2);
        idle_steps(3);
        for (int i = 0; i < SLOT + 4; i++) step(1'b1, 4'd3);

        // Enable dropped on the edge that ends the final SHOW slot, so frame_done must still have pulsed.
        idle_steps(2);
        for (int i = 0; i < FRAME; i++) step(1'b1, 4'd9);
        idle_steps(2);

        // Asynchronous reset mid-frame with the clock stopped.
        for (int i = 0; i < 13; i++) step(1'b1, 4'd7);
        @(negedge clk);
        #1;
        clk_run = 1'b0;
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("reset_async_midframe");
        m_run = 1'b0;
        exp_q.delete();
        #3 rst_n = 1'b1;
        #1 clk_run = 1'b1;
        for (int i = 0; i < SLOT + 2; i++) step(1'b1, 4'd7);
        idle_steps(2);

        fill_rom_random();
        for (int i = 0; i < 900; i++) begin
            logic en;
            logic [ADDR-1:0] b;
            en = m_run ? ($urandom_range(0, 99) < 96) : ($urandom_range(0, 99) < 50);
            b  = ($urandom_range(0, 99) < 6) ? ADDR'($urandom) : base_addr;
            step(en, b);
        end
        idle_steps(2);

        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
